// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI response collector: command codes,
// expected response length per command, and the collector state enum.
package spi_cmd_pkg;

  typedef enum logic [2:0] {
    CMD_NOP       = 3'd0,
    CMD_RD_STATUS = 3'd1,
    CMD_RD_CFG    = 3'd2,
    CMD_RD_ID16   = 3'd3,
    CMD_RD_REG16  = 3'd4,
    CMD_RD_ADDR24 = 3'd5,
    CMD_RD_DATA32 = 3'd6,
    CMD_RD_CRC32  = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } coll_state_e;

  function automatic logic [2:0] expected_bytes(input cmd_e cmd);
    expected_bytes = 3'd0;
    case (cmd)
      CMD_NOP:       expected_bytes = 3'd0;
      CMD_RD_STATUS: expected_bytes = 3'd1;
      CMD_RD_CFG:    expected_bytes = 3'd1;
      CMD_RD_ID16:   expected_bytes = 3'd2;
      CMD_RD_REG16:  expected_bytes = 3'd2;
      CMD_RD_ADDR24: expected_bytes = 3'd3;
      CMD_RD_DATA32: expected_bytes = 3'd4;
      CMD_RD_CRC32:  expected_bytes = 3'd4;
      default:       expected_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/response_timeout_counter.sv
// Saturating inter-byte silence counter. expired_o flags the enabled cycle
// whose increment reaches TIMEOUT_CYCLES, so the owner can abort on that edge.
module response_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST  = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = enable_i && !clear_i && (count_q >= LAST);

endmodule

// File: rtl/spi_response_collector.sv
// Collects the response bytes for an issued SPI command into a right-justified
// word and holds it until downstream accepts it, aborting on inter-byte timeout.
module spi_response_collector
  import spi_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  command,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        out_ready,
  output logic [31:0] word,
  output logic [2:0]  word_len,
  output logic        word_valid,
  output logic        busy,
  output logic        timeout_err,
  output logic        overrun
);

  coll_state_e state_q;
  logic [2:0]  expect_q;
  logic [31:0] word_q;
  logic [2:0]  word_len_q;
  logic        word_valid_q;
  logic        busy_q;
  logic        timeout_err_q;
  logic        overrun_q;
  logic [2:0]  start_expect;

  logic tmo_clear, tmo_enable, tmo_expired;

  // Silence is only counted while collecting; any accepted byte restarts it.
  assign tmo_clear  = (state_q != ST_COLLECT) || rx_valid;
  assign tmo_enable = (state_q == ST_COLLECT) && !rx_valid;

  response_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk),
    .rst_i    (rst),
    .clear_i  (tmo_clear),
    .enable_i (tmo_enable),
    .expired_o(tmo_expired)
  );

  assign start_expect = expected_bytes(cmd_e'(command));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      expect_q      <= '0;
      word_q        <= '0;
      word_len_q    <= '0;
      word_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      if (rx_valid && (state_q != ST_COLLECT)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            expect_q      <= start_expect;
            word_q        <= '0;
            word_len_q    <= '0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b1;
            if (start_expect == 3'd0) begin
              state_q      <= ST_HOLD;
              word_valid_q <= 1'b1;
            end else begin
              state_q <= ST_COLLECT;
            end
          end
        end
        ST_COLLECT: begin
          if (rx_valid) begin
            word_q     <= {word_q[23:0], rx_byte};
            word_len_q <= word_len_q + 3'd1;
            if ((word_len_q + 3'd1) == expect_q) begin
              state_q      <= ST_HOLD;
              word_valid_q <= 1'b1;
            end
          end else if (tmo_expired) begin
            state_q       <= ST_HOLD;
            word_valid_q  <= 1'b1;
            timeout_err_q <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_q      <= ST_IDLE;
            word_valid_q <= 1'b0;
            busy_q       <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign word        = word_q;
  assign word_len    = word_len_q;
  assign word_valid  = word_valid_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_spi_response_collector.sv
// Bench for spi_response_collector: directed table, corner sequences, and
// random transactions checked against a transaction-level expectation model.
module tb_spi_response_collector;

  localparam int unsigned TMO = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  command = '0;
  logic [7:0]  rx_byte = '0;
  logic        rx_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] word;
  logic [2:0]  word_len;
  logic        word_valid;
  logic        busy;
  logic        timeout_err;
  logic        overrun;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  bit          exp_overrun = 1'b0;
  int unsigned EXP_BYTES [8] = '{0, 1, 1, 2, 2, 3, 4, 4};

  spi_response_collector #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .command(command), .rx_byte(rx_byte),
    .rx_valid(rx_valid), .out_ready(out_ready), .word(word), .word_len(word_len),
    .word_valid(word_valid), .busy(busy), .timeout_err(timeout_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  cmd;
    logic [31:0] bytes;   // first byte in [31:24]
    logic [31:0] gaps;    // idle cycles before each byte, same layout
    int unsigned hold;
    logic [31:0] exp_word;
    logic [2:0]  exp_len;
    logic        exp_terr;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    exp_overrun = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_word"}, word, 32'h0);
    check({tag, "_len"}, {29'b0, word_len}, 32'h0);
    check({tag, "_valid"}, {31'b0, word_valid}, 32'h0);
    check({tag, "_busy"}, {31'b0, busy}, 32'h0);
    check({tag, "_terr"}, {31'b0, timeout_err}, 32'h0);
    check({tag, "_overrun"}, {31'b0, overrun}, 32'h0);
  endtask

  // Expected result from the command's byte count and the gap schedule.
  task automatic model(input logic [2:0] cmd, input logic [31:0] bytes, input logic [31:0] gaps,
                       output logic [31:0] w, output logic [2:0] len, output logic terr);
    int unsigned n;
    n = EXP_BYTES[cmd];
    w = '0; len = '0; terr = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      if (32'(gaps[31-8*i -: 8]) >= TMO) begin
        terr = 1'b1;
        break;
      end
      w = (w << 8) | 32'(bytes[31-8*i -: 8]);
      len = len + 3'd1;
    end
  endtask

  task automatic run_txn(input logic [2:0] cmd, input logic [31:0] bytes, input logic [31:0] gaps,
                         input int unsigned hold, input bit junk, input logic [31:0] exp_word,
                         input logic [2:0] exp_len, input logic exp_terr);
    int unsigned n;
    int unsigned acc;
    bit tmo;
    n = EXP_BYTES[cmd];
    acc = 0;
    tmo = 1'b0;
    start = 1'b1; command = cmd;
    tick();
    start = 1'b0;
    check("busy_after_start", {31'b0, busy}, 32'h1);
    for (int unsigned i = 0; i < n && !tmo; i++) begin
      int unsigned g;
      g = 32'(gaps[31-8*i -: 8]);
      for (int unsigned k = 1; k <= g; k++) begin
        tick();
        if (k == TMO) begin
          tmo = 1'b1;
          break;
        end
        check("quiet_collect", {31'b0, word_valid}, 32'h0);
      end
      if (!tmo) begin
        rx_byte = bytes[31-8*i -: 8];
        rx_valid = 1'b1;
        if (junk && i == 0) begin
          start = 1'b1;
          command = ~cmd;
        end
        tick();
        rx_valid = 1'b0; start = 1'b0;
        acc++;
        if (acc < n) check("no_early_valid", {31'b0, word_valid}, 32'h0);
      end
    end
    check("valid", {31'b0, word_valid}, 32'h1);
    check("word", word, exp_word);
    check("len", {29'b0, word_len}, {29'b0, exp_len});
    check("terr", {31'b0, timeout_err}, {31'b0, exp_terr});
    check("busy_hold", {31'b0, busy}, 32'h1);
    for (int unsigned h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      if (junk && h == 0) begin
        rx_valid = 1'b1; rx_byte = 8'($urandom); start = 1'b1;
        exp_overrun = 1'b1;
      end
      tick();
      rx_valid = 1'b0; start = 1'b0;
      check("hold_valid", {31'b0, word_valid}, 32'h1);
      check("hold_word", word, exp_word);
      check("hold_len", {29'b0, word_len}, {29'b0, exp_len});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("released_valid", {31'b0, word_valid}, 32'h0);
    check("released_busy", {31'b0, busy}, 32'h0);
    check("overrun", {31'b0, overrun}, {31'b0, exp_overrun});
  endtask

  vec_t vecs [8];

  initial begin
    logic [31:0] mw;
    logic [2:0]  ml;
    logic        mt;

    vecs[0] = '{3'd3, 32'hA53C_0000, 32'h0000_0000, 0, 32'h0000_A53C, 3'd2, 1'b0};
    vecs[1] = '{3'd6, 32'h0102_0304, 32'h0001_0002, 5, 32'h0102_0304, 3'd4, 1'b0};
    vecs[2] = '{3'd5, 32'h7E00_0000, 32'h0014_0000, 1, 32'h0000_007E, 3'd1, 1'b1};
    vecs[3] = '{3'd0, 32'h0000_0000, 32'h0000_0000, 2, 32'h0000_0000, 3'd0, 1'b0};
    vecs[4] = '{3'd7, 32'hDEAD_BEEF, 32'h0013_0000, 1, 32'hDEAD_BEEF, 3'd4, 1'b0};
    vecs[5] = '{3'd1, 32'h5500_0000, 32'h1400_0000, 0, 32'h0000_0000, 3'd0, 1'b1};
    vecs[6] = '{3'd2, 32'h8000_0000, 32'h0300_0000, 3, 32'h0000_0080, 3'd1, 1'b0};
    vecs[7] = '{3'd4, 32'h1122_0000, 32'h0019_0000, 0, 32'h0000_0011, 3'd1, 1'b1};

    do_reset();
    check_reset_outputs("reset");

    foreach (vecs[i]) begin
      run_txn(vecs[i].cmd, vecs[i].bytes, vecs[i].gaps, vecs[i].hold, 1'b0,
              vecs[i].exp_word, vecs[i].exp_len, vecs[i].exp_terr);
    end

    // Stray byte in IDLE, then a start during COLLECT must not relatch the count.
    do_reset();
    rx_valid = 1'b1; rx_byte = 8'h55;
    tick();
    rx_valid = 1'b0;
    exp_overrun = 1'b1;
    check("idle_byte_overrun", {31'b0, overrun}, 32'h1);
    check("idle_byte_busy", {31'b0, busy}, 32'h0);
    run_txn(3'd3, 32'hC0DE_0000, 32'h0200_0000, 2, 1'b1, 32'h0000_C0DE, 3'd2, 1'b0);

    // start and rx_valid together in IDLE: start wins, byte dropped.
    do_reset();
    start = 1'b1; command = 3'd2; rx_valid = 1'b1; rx_byte = 8'h99;
    tick();
    start = 1'b0; rx_valid = 1'b0;
    check("same_cycle_overrun", {31'b0, overrun}, 32'h1);
    check("same_cycle_busy", {31'b0, busy}, 32'h1);
    check("same_cycle_valid", {31'b0, word_valid}, 32'h0);
    rx_valid = 1'b1; rx_byte = 8'h42;
    tick();
    rx_valid = 1'b0;
    check("same_cycle_word", word, 32'h0000_0042);
    check("same_cycle_len", {29'b0, word_len}, 32'h1);
    check("same_cycle_done", {31'b0, word_valid}, 32'h1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset mid-COLLECT abandons the response.
    do_reset();
    start = 1'b1; command = 3'd3;
    tick();
    start = 1'b0;
    rx_valid = 1'b1; rx_byte = 8'h12;
    tick();
    rx_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("rst_collect");
    for (int unsigned k = 0; k < 3; k++) begin
      tick();
      check("rst_collect_quiet", {31'b0, word_valid}, 32'h0);
    end

    // Reset mid-HOLD.
    start = 1'b1; command = 3'd0;
    tick();
    start = 1'b0;
    check("nop_hold_valid", {31'b0, word_valid}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("rst_hold");
    exp_overrun = 1'b0;

    for (int unsigned t = 0; t < 40; t++) begin
      logic [2:0]  cmd;
      logic [31:0] bytes, gaps;
      cmd = 3'($urandom_range(0, 7));
      bytes = $urandom;
      gaps = '0;
      for (int unsigned i = 0; i < 4; i++) begin
        if ($urandom_range(0, 9) == 0) gaps[31-8*i -: 8] = 8'($urandom_range(18, 22));
        else gaps[31-8*i -: 8] = 8'($urandom_range(0, 3));
      end
      model(cmd, bytes, gaps, mw, ml, mt);
      run_txn(cmd, bytes, gaps, $urandom_range(0, 3), 1'($urandom_range(0, 1)), mw, ml, mt);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
